mmio_data_mem: RTL and testbench

Parametrised data memory with a memory-mapped I/O window: the CPU's data-side port for loads and stores. It holds a word-addressed RAM of DEPTH words at RAM_BASE, plus three I/O registers:
- a byte-writable LED output register
- a synchronised, optionally debounced switch input
- a free-running, writable 32-bit cycle counter

Read data is registered (1-cycle latency) and flagged with `rvalid`. Store paths use per-byte strobes.

---
 rtl/mmio_data_mem.sv | 140 ++++++++++++++
 tb/tb_mmio_data_mem.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_data_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_data_mem : word-addressed data RAM plus LED / switch / cycle-counter  |
// |   MMIO registers, registered read data. Define MMIO_DEBOUNCE_EN to build   |
// |   the switch debouncer.                                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmio_data_mem #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] RAM_BASE  = 32'h0000_4000,
  parameter logic [31:0] LED_ADDR  = 32'hFFFF_F060,
  parameter logic [31:0] SW_ADDR   = 32'hFFFF_F070,
  parameter logic [31:0] CNT_ADDR  = 32'hFFFF_F080,
  parameter int          LED_W     = 24,
  parameter int          SW_W      = 24,
  parameter int          DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wr,
  input  logic              re,
  output logic [31:0]       rd,
  output logic              rvalid,
  input  logic [SW_W-1:0]   device_sw,
  output logic [LED_W-1:0]  device_led
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      rd_q, rd_d;
  logic             rvalid_q;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [SW_W-1:0]  sync1_q, sync_q, stable_q;

  logic [29:0]      w_off;
  logic [AW-1:0]    w_idx;
  logic             w_ram_hit, w_led_hit, w_sw_hit, w_cnt_hit, w_mem_we;
  logic             w_unused;

  assign w_off     = addr[31:2] - RAM_BASE[31:2];
  assign w_idx     = w_off[AW-1:0];
  assign w_ram_hit = (addr[31:2] >= RAM_BASE[31:2]) && ({2'b00, w_off} < 32'(DEPTH));
  assign w_led_hit = (addr[31:2] == LED_ADDR[31:2]);
  assign w_sw_hit  = (addr[31:2] == SW_ADDR[31:2]);
  assign w_cnt_hit = (addr[31:2] == CNT_ADDR[31:2]);
  // A store landing on the edge where reset is already asserted is discarded.
  assign w_mem_we  = we && w_ram_hit && rst_n;

  always_comb begin
    led_d = led_q;
    if (we && w_led_hit) begin
      for (int b = 0; b < LED_W; b++) begin
        if (wstrb[b/8]) led_d[b] = wr[b];
      end
    end

    // Store lanes override the increment; untouched lanes still advance.
    cnt_d = cnt_q + 32'd1;
    if (we && w_cnt_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) cnt_d[8*i +: 8] = wr[8*i +: 8];
      end
    end

    rd_d = '0;
    if (w_ram_hit)      rd_d = mem_q[w_idx];
    else if (w_led_hit) rd_d = 32'(led_q);
    else if (w_sw_hit)  rd_d = 32'(stable_q);
    else if (w_cnt_hit) rd_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[w_idx][8*i +: 8] <= wr[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
      led_q    <= '0;
      cnt_q    <= '0;
      sync1_q  <= '0;
      sync_q   <= '0;
    end else begin
      rvalid_q <= re;
      if (re) rd_q <= rd_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      sync1_q  <= device_sw;
      sync_q   <= sync1_q;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int            DBW    = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);

  logic [SW_W-1:0] cand_q;
  logic [DBW-1:0]  db_cnt_q;

  assign w_unused = ^addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      db_cnt_q <= '0;
      stable_q <= '0;
    end else if (sync_q != cand_q) begin
      cand_q   <= sync_q;
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_MAX) begin
      stable_q <= cand_q;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end
`else
  assign w_unused = ^addr[1:0] ^ (DB_CYCLES > 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_q <= '0;
    else        stable_q <= sync_q;
  end
`endif

  assign rd         = rd_q;
  assign rvalid     = rvalid_q;
  assign device_led = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_data_mem.sv
`default_nettype none
// Bench for mmio_data_mem: behavioural model checked every cycle plus directed
// literal expectations.
module tb_mmio_data_mem;
  localparam int          DEPTH  = 16;
  localparam int          LED_W  = 24;
  localparam int          SW_W   = 24;
  localparam int          DB     = 16;
  localparam logic [31:0] RAMB   = 32'h0000_4000;
  localparam logic [31:0] LEDA   = 32'hFFFF_F060;
  localparam logic [31:0] SWA    = 32'hFFFF_F070;
  localparam logic [31:0] CNTA   = 32'hFFFF_F080;
`ifdef MMIO_DEBOUNCE_EN
  localparam int          WIN    = DB + 1;
`else
  localparam int          WIN    = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      addr, wr, rd;
  logic             we, re, rvalid;
  logic [3:0]       wstrb;
  logic [SW_W-1:0]  device_sw;
  logic [LED_W-1:0] device_led;

  mmio_data_mem #(
    .DEPTH(DEPTH), .RAM_BASE(RAMB), .LED_ADDR(LEDA), .SW_ADDR(SWA),
    .CNT_ADDR(CNTA), .LED_W(LED_W), .SW_W(SW_W), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wstrb(wstrb), .wr(wr),
    .re(re), .rd(rd), .rvalid(rvalid), .device_sw(device_sw),
    .device_led(device_led)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Model state
  logic [31:0]      m_mem [DEPTH];
  logic [LED_W-1:0] m_led;
  logic [31:0]      m_cnt, m_rd;
  logic             m_rvalid;
  logic [SW_W-1:0]  m_stable;
  logic [SW_W-1:0]  m_hist [WIN+2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_led = '0; m_cnt = '0; m_rd = '0; m_rvalid = 1'b0; m_stable = '0;
      for (int i = 0; i < WIN + 2; i++) m_hist[i] = '0;
    end else begin
      logic [31:0] rv, tmp;
      logic        is_ram, all_eq;
      int          idx;
      is_ram = (addr >= RAMB) && (((addr - RAMB) >> 2) < DEPTH);
      idx    = int'((addr - RAMB) >> 2);
      rv     = 32'h0;
      if (is_ram)                      rv = m_mem[idx];
      else if ((addr >> 2) == (LEDA >> 2)) rv = 32'(m_led);
      else if ((addr >> 2) == (SWA >> 2))  rv = 32'(m_stable);
      else if ((addr >> 2) == (CNTA >> 2)) rv = m_cnt;
      if (re) m_rd = rv;
      m_rvalid = re;
      if (we && is_ram) m_mem[idx] = merge(m_mem[idx], wr, wstrb);
      if (we && !is_ram && (addr >> 2) == (LEDA >> 2)) begin
        tmp   = merge(32'(m_led), wr, wstrb);
        m_led = tmp[LED_W-1:0];
      end
      if (we && !is_ram && (addr >> 2) == (CNTA >> 2)) m_cnt = merge(m_cnt + 1, wr, wstrb);
      else                                             m_cnt = m_cnt + 1;
      for (int i = WIN + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = device_sw;
      all_eq = 1'b1;
      for (int i = 2; i <= WIN + 1; i++) if (m_hist[i] !== m_hist[2]) all_eq = 1'b0;
      if (all_eq) m_stable = m_hist[2];
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("model_rd", rd, m_rd);
      chk("model_led", 32'(device_led), 32'(m_led));
    end
  end

  task automatic op(input logic [31:0] a, input logic w, input logic [3:0] s,
                    input logic [31:0] d, input logic r);
    addr = a; we = w; wstrb = s; wr = d; re = r;
    @(negedge clk);
  endtask

  task automatic rdop(input logic [31:0] a);
    op(a, 1'b0, 4'h0, 32'h0, 1'b1);
  endtask

  initial begin
    int first;
    addr = '0; we = 1'b0; wstrb = '0; wr = '0; re = 1'b0; device_sw = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd", rd, 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_led", 32'(device_led), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    rdop(CNTA); chk("cnt_first", rd, 32'h0);
    rdop(CNTA); chk("cnt_second", rd, 32'h1);

    for (int i = 0; i < DEPTH; i++) op(RAMB + 32'(4*i), 1'b1, 4'hF, 32'hA500_0000 | 32'(i), 1'b0);

    op(32'h4004, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0);
    op(32'h4004, 1'b1, 4'h1, 32'h0000_0011, 1'b0);
    rdop(32'h4004);
    chk("ram_byte", rd, 32'hDEAD_BE11);
    chk("ram_rvalid", 32'(rvalid), 32'h1);
    op(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    chk("rvalid_drop", 32'(rvalid), 32'h0);
    op(32'h4000, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0);

    op(32'h4040, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0);
    rdop(32'h4040); chk("ram_oob", rd, 32'h0);
    rdop(32'h3FFC); chk("ram_below", rd, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      rdop(RAMB + 32'(4*i));
      chk("ram_intact", rd, (i == 1) ? 32'hDEAD_BE11 : (32'hA500_0000 | 32'(i)));
    end

    op(LEDA, 1'b1, 4'b0011, 32'h00AB_CDEF, 1'b0);
    chk("led_write", 32'(device_led), 32'h0000_CDEF);
    rdop(LEDA); chk("led_read", rd, 32'h0000_CDEF);
    op(SWA, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
    rdop(SWA); chk("sw_ignore_wr", rd, 32'h0);
    op(LEDA, 1'b1, 4'b1100, 32'h1234_5678, 1'b0);
    chk("led_upper", 32'(device_led), 32'h0034_CDEF);

    op(CNTA, 1'b1, 4'hF, 32'hFFFF_FFFE, 1'b0);
    rdop(CNTA); chk("cnt_fe", rd, 32'hFFFF_FFFE);
    rdop(CNTA); chk("cnt_ff", rd, 32'hFFFF_FFFF);
    rdop(CNTA); chk("cnt_wrap", rd, 32'h0);
    op(CNTA, 1'b1, 4'hF, 32'h1234_5678, 1'b1); chk("cnt_rbw", rd, 32'h1);
    rdop(CNTA); chk("cnt_loaded", rd, 32'h1234_5678);
    op(CNTA, 1'b1, 4'h1, 32'h0000_00AA, 1'b0);
    rdop(CNTA); chk("cnt_lane", rd, 32'h1234_56AA);

    op(32'h4008, 1'b1, 4'hF, 32'h1122_3344, 1'b1); chk("ram_rbw_old", rd, 32'hA500_0002);
    rdop(32'h4008); chk("ram_rbw_new", rd, 32'h1122_3344);

    device_sw = 24'h000001;
    for (int i = 0; i < 5; i++) rdop(SWA);
    device_sw = '0;
    for (int i = 0; i < 30; i++) rdop(SWA);
    chk("sw_low", rd, 32'h0);
    device_sw = 24'h000001;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      rdop(SWA);
      if (first < 0 && rd == 32'h1) first = i;
    end
    chk("sw_latency", 32'(first), 32'(WIN + 2));
    chk("sw_high", rd, 32'h1);

    op(32'h4010, 1'b1, 4'hF, 32'h5A5A_0F0F, 1'b0);
    rdop(32'h4004);
    addr = 32'h4010; re = 1'b1; we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rd", rd, 32'h0);
    chk("rst_led", 32'(device_led), 32'h0);
    @(negedge clk); @(negedge clk);
    re = 1'b0;
    rst_n = 1'b1;
    rdop(32'h4010); chk("ram_keep", rd, 32'h5A5A_0F0F);
    rdop(LEDA); chk("led_after_rst", rd, 32'h0);
    op(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
